// File: rtl/vending_pkg.sv
// Shared types and constants for the two-product vending controller.
//
// Contents:
//   state_t            controller state: IDLE (no credit), COLLECT (credit held),
//                      VEND (one-cycle dispense)
//   NICKEL_V/DIME_V/QUARTER_V  coin values in 5c units
//   PRICE_NICKELS_DEF  default product price in 5c units (35c)
//   CREDIT_W_DEF       default credit register width in 5c units
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2
   } state_t;

   localparam logic [3:0] NICKEL_V  = 4'd1;
   localparam logic [3:0] DIME_V    = 4'd2;
   localparam logic [3:0] QUARTER_V = 4'd5;

   localparam int PRICE_NICKELS_DEF = 7;
   localparam int CREDIT_W_DEF      = 5;

endpackage

// File: rtl/vend_coin_adder.sv
// Combinational coin accumulator for the vending controller.
//
// Sums the one-cycle coin pulses into a nickel count (0..8) and adds it to a
// base credit value, clamping at the all-ones credit value. Coin value lost to
// clamping is intentionally discarded.
//
// Ports:
//   nickel, dime, quarter  in   coin pulses, any combination may be high
//   base                   in   credit before coins (CREDIT_W bits, nickels)
//   sum                    out  saturated base + coins (CREDIT_W bits, nickels)
module vend_coin_adder
   import vending_pkg::*;
#(
   parameter int CREDIT_W = CREDIT_W_DEF
) (
   input  logic                nickel,
   input  logic                dime,
   input  logic                quarter,
   input  logic [CREDIT_W-1:0] base,
   output logic [CREDIT_W-1:0] sum
);

   logic [3:0]        coins;
   logic [CREDIT_W:0] ext;

   assign coins = (nickel  ? NICKEL_V  : 4'd0)
                + (dime    ? DIME_V    : 4'd0)
                + (quarter ? QUARTER_V : 4'd0);

   // One extra bit is enough: base <= 2^W-1 and coins <= 8, so the carry
   // bit alone flags overflow.
   assign ext = {1'b0, base} + (CREDIT_W+1)'(coins);
   assign sum = ext[CREDIT_W] ? {CREDIT_W{1'b1}} : ext[CREDIT_W-1:0];

endmodule

// File: rtl/vending_machine.sv
// Two-product (regular/diet soda) vending controller.
//
// Accumulates coin credit in 5c units and issues a registered one-cycle
// dispense pulse the cycle after a paid-for selection is decided. Coins that
// arrive in the decision cycle are added after the price is deducted.
// The VEND state lasts one cycle; selections are ignored there, so a held
// selection re-vends at most every other cycle.
//
// Optional feature macro: VEND_CHANGE_EN
//   defined   - adds change_out; on a vend the remaining credit is returned on
//               change_out during the VEND cycle and credit is cleared.
//   undefined - residual credit carries over to the next purchase.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-low reset
//   quarter     in   25c coin pulse
//   nickel      in   5c coin pulse
//   dime        in   10c coin pulse
//   soda        in   regular soda select pulse
//   diet        in   diet soda select pulse
//   sodaO       out  regular soda dispense pulse (registered)
//   dietO       out  diet soda dispense pulse (registered)
//   change_out  out  returned change in nickels (VEND_CHANGE_EN only)
module vending_machine
   import vending_pkg::*;
#(
   parameter int PRICE_NICKELS = PRICE_NICKELS_DEF,
   parameter int CREDIT_W      = CREDIT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                quarter,
   input  logic                nickel,
   input  logic                dime,
   input  logic                soda,
   input  logic                diet,
   output logic                sodaO,
   output logic                dietO
`ifdef VEND_CHANGE_EN
   ,
   output logic [CREDIT_W-1:0] change_out
`endif
);

   localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_NICKELS);

   state_t              state;
   state_t              state_next;
   logic [CREDIT_W-1:0] credit;
   logic [CREDIT_W-1:0] credit_next;
   logic [CREDIT_W-1:0] base;
   logic [CREDIT_W-1:0] added;
   logic                vend;
`ifdef VEND_CHANGE_EN
   logic [CREDIT_W-1:0] change_next;
`endif

   // Decision uses credit before this cycle's coins; both buttons at once
   // is treated as no selection.
   assign vend = (soda ^ diet) && (credit >= PRICE) && (state != VEND);
   assign base = vend ? (credit - PRICE) : credit;

   vend_coin_adder #(
      .CREDIT_W(CREDIT_W)
   ) u_coin_adder (
      .nickel (nickel),
      .dime   (dime),
      .quarter(quarter),
      .base   (base),
      .sum    (added)
   );

   always_comb begin
      state_next  = state;
      credit_next = added;
`ifdef VEND_CHANGE_EN
      change_next = '0;
      if (vend) begin
         change_next = added;
         credit_next = '0;
      end
`endif
      // IDLE always means zero credit, so the next state follows from the
      // vend decision and the credit that will be held next cycle.
      if (vend) begin
         state_next = VEND;
      end else if (credit_next == '0) begin
         state_next = IDLE;
      end else begin
         state_next = COLLECT;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         credit <= '0;
         sodaO  <= 1'b0;
         dietO  <= 1'b0;
`ifdef VEND_CHANGE_EN
         change_out <= '0;
`endif
      end else begin
         state  <= state_next;
         credit <= credit_next;
         sodaO  <= vend & soda;
         dietO  <= vend & diet;
`ifdef VEND_CHANGE_EN
         change_out <= change_next;
`endif
      end
   end

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine (default and VEND_CHANGE_EN builds).
module tb_vending_machine;
   import vending_pkg::*;

   localparam int CW = 5;
`ifdef VEND_CHANGE_EN
   localparam bit CH = 1'b1;
`else
   localparam bit CH = 1'b0;
`endif

   // clock / reset / dut
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic quarter = 1'b0, nickel = 1'b0, dime = 1'b0, soda = 1'b0, diet = 1'b0;
   logic sodaO, dietO;
   logic [CW-1:0] change_out;

   always #5 clk = ~clk;

   vending_machine #(
      .PRICE_NICKELS(7),
      .CREDIT_W(CW)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .quarter(quarter),
      .nickel (nickel),
      .dime   (dime),
      .soda   (soda),
      .diet   (diet),
      .sodaO  (sodaO),
      .dietO  (dietO)
`ifdef VEND_CHANGE_EN
      ,
      .change_out(change_out)
`endif
   );
`ifndef VEND_CHANGE_EN
   assign change_out = '0;
`endif

   // vector record: inputs, then expected outputs after the edge
   typedef struct packed {
      logic          r, n, d, q, s, t;
      logic          eso, edo;
      logic [CW-1:0] cr;
      logic [1:0]    st;
      logic [CW-1:0] ch;
   } vec_t;

   localparam int NV = 34;
   vec_t tbl[NV];

   // scoreboard
   logic [13:0] exp_q[$];
   int total = 0;
   int bad = 0;

   function automatic vec_t mk(input logic r, n, d, q, s, t, eso, edo,
                               input int cr, input state_t st, input int ch);
      vec_t v;
      v.r = r; v.n = n; v.d = d; v.q = q; v.s = s; v.t = t;
      v.eso = eso; v.edo = edo;
      v.cr = CW'(cr);
      v.st = st;
      v.ch = CW'(ch);
      return v;
   endfunction

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
      end
   endtask

   // driver: apply one cycle of inputs, push expectation, compare after edge
   task automatic step(input vec_t v);
      logic [13:0] e;
      @(negedge clk);
      reset = v.r; nickel = v.n; dime = v.d; quarter = v.q; soda = v.s; diet = v.t;
      exp_q.push_back({v.eso, v.edo, v.cr, v.st, v.ch});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty @%0t", $time);
      end else begin
         e = exp_q.pop_front();
         check("sodaO", CW'(sodaO), CW'(e[13]));
         check("dietO", CW'(dietO), CW'(e[12]));
         check("credit", dut.credit, e[11:7]);
         check("state", CW'(dut.state), CW'(e[6:5]));
         if (CH) check("change_out", change_out, e[4:0]);
      end
   endtask

   initial begin
      // reset, exact 35c purchase, insufficient credit, overpay/carry
      tbl[0]  = mk(0,0,0,0,0,0, 0,0, 0, IDLE, 0);
      tbl[1]  = mk(0,0,0,0,0,0, 0,0, 0, IDLE, 0);
      tbl[2]  = mk(1,0,0,0,0,0, 0,0, 0, IDLE, 0);
      tbl[3]  = mk(1,0,0,1,0,0, 0,0, 5, COLLECT, 0);
      tbl[4]  = mk(1,0,1,0,0,0, 0,0, 7, COLLECT, 0);
      tbl[5]  = mk(1,0,0,0,1,0, 1,0, 0, VEND, 0);
      tbl[6]  = mk(1,0,0,0,0,0, 0,0, 0, IDLE, 0);
      tbl[7]  = mk(1,0,0,1,0,0, 0,0, 5, COLLECT, 0);
      tbl[8]  = mk(1,0,0,0,0,1, 0,0, 5, COLLECT, 0);
      tbl[9]  = mk(1,0,0,0,0,0, 0,0, 5, COLLECT, 0);
      tbl[10] = mk(1,0,1,0,0,0, 0,0, 7, COLLECT, 0);
      tbl[11] = mk(1,0,0,0,0,1, 0,1, 0, VEND, 0);
      tbl[12] = mk(1,0,0,0,0,0, 0,0, 0, IDLE, 0);
      tbl[13] = mk(1,0,0,1,0,0, 0,0, 5, COLLECT, 0);
      tbl[14] = mk(1,0,0,1,0,0, 0,0, 10, COLLECT, 0);
      tbl[15] = mk(1,0,0,0,1,0, 1,0, CH ? 0 : 3, VEND, CH ? 3 : 0);
      tbl[16] = mk(1,0,0,0,0,0, 0,0, CH ? 0 : 3, CH ? IDLE : COLLECT, 0);
      // simultaneous events and saturation
      tbl[17] = mk(0,0,0,0,0,0, 0,0, 0, IDLE, 0);
      tbl[18] = mk(1,0,0,1,0,0, 0,0, 5, COLLECT, 0);
      tbl[19] = mk(1,0,1,0,0,0, 0,0, 7, COLLECT, 0);
      tbl[20] = mk(1,0,0,0,1,1, 0,0, 7, COLLECT, 0);
      tbl[21] = mk(1,1,1,1,0,0, 0,0, 15, COLLECT, 0);
      tbl[22] = mk(0,0,0,0,0,0, 0,0, 0, IDLE, 0);
      tbl[23] = mk(1,0,0,1,0,0, 0,0, 5, COLLECT, 0);
      tbl[24] = mk(1,0,0,1,0,0, 0,0, 10, COLLECT, 0);
      tbl[25] = mk(1,0,0,1,0,0, 0,0, 15, COLLECT, 0);
      tbl[26] = mk(1,0,0,1,0,0, 0,0, 20, COLLECT, 0);
      tbl[27] = mk(1,0,0,1,0,0, 0,0, 25, COLLECT, 0);
      tbl[28] = mk(1,0,0,1,0,0, 0,0, 30, COLLECT, 0);
      tbl[29] = mk(1,0,0,1,0,0, 0,0, 31, COLLECT, 0);
      // vend from full credit with a coin in the decision cycle, then held soda
      tbl[30] = mk(1,0,0,1,1,0, 1,0, CH ? 0 : 29, VEND, CH ? 29 : 0);
      tbl[31] = mk(1,0,0,0,1,0, 0,0, CH ? 0 : 29, CH ? IDLE : COLLECT, 0);
      tbl[32] = mk(1,0,0,0,1,0, CH ? 0 : 1,0, CH ? 0 : 22, CH ? IDLE : VEND, 0);
      tbl[33] = mk(1,0,0,0,0,0, 0,0, CH ? 0 : 22, CH ? IDLE : COLLECT, 0);

      for (int i = 0; i < NV; i++) step(tbl[i]);

      // reset asserted in the VEND cycle beats coins and selection
      step(mk(0,0,0,0,0,0, 0,0, 0, IDLE, 0));
      step(mk(1,0,0,1,0,0, 0,0, 5, COLLECT, 0));
      step(mk(1,0,0,1,0,0, 0,0, 10, COLLECT, 0));
      step(mk(1,0,0,0,1,0, 1,0, CH ? 0 : 3, VEND, CH ? 3 : 0));
      step(mk(0,0,0,1,0,1, 0,0, 0, IDLE, 0));

      // diet vend with a nickel in the decision cycle, dime during VEND
      step(mk(1,0,0,1,0,0, 0,0, 5, COLLECT, 0));
      step(mk(1,0,1,0,0,0, 0,0, 7, COLLECT, 0));
      step(mk(1,1,0,0,0,1, 0,1, CH ? 0 : 1, VEND, CH ? 1 : 0));
      step(mk(1,0,1,0,0,0, 0,0, CH ? 2 : 3, COLLECT, 0));

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // never-both-outputs invariant, checked every cycle away from the edge
   always @(negedge clk) begin
      if (sodaO && dietO) begin
         total++;
         bad++;
         $display("FAIL both_outputs @%0t: got sodaO=1 dietO=1 want at most one", $time);
      end
   end

endmodule
